// File: rtl/demux1x2_4b_buf.sv
// 1-to-2 demultiplexer for 4-bit words. Each destination has its own
// first-word-fall-through buffer, so the two consumers can stall independently.

module demux1x2_4b_buf_chan #(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [3:0]               wr_data,
   input  logic                     pop_req,
   output logic [3:0]               rd_data,
   output logic                     valid,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int PW = $clog2(DEPTH);

   logic [3:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          pop;

   // DEPTH is a power of two, so the level MSB is set only when the buffer is full.
   assign full  = level[PW];
   assign valid = (level != '0);
   assign pop   = pop_req & valid;

   // The head word is forced to zero while empty so stale storage never shows.
   assign rd_data = valid ? mem[rd_ptr] : 4'b0000;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

   // Storage needs no reset: pointers and level define what is visible.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

endmodule

module demux1x2_4b_buf #(
   parameter int DEPTH = 2
) (
   input  logic                     Clk,
   input  logic                     Rst_n,
   input  logic [3:0]               In,
   input  logic                     InValid,
   output logic                     InReady,
   input  logic                     Sel,
   output logic [3:0]               A,
   output logic                     ValidA,
   input  logic                     ReadyA,
   output logic [3:0]               B,
   output logic                     ValidB,
   input  logic                     ReadyB,
   output logic [$clog2(DEPTH):0]   LevelA,
   output logic [$clog2(DEPTH):0]   LevelB
);

   logic full_a;
   logic full_b;
   logic push_a;
   logic push_b;

   // Readiness looks only at the selected channel's stored level; a pop in the
   // same cycle does not free a slot for the incoming word.
   assign InReady = Sel ? ~full_b : ~full_a;
   assign push_a  = InValid & InReady & ~Sel;
   assign push_b  = InValid & InReady &  Sel;

   demux1x2_4b_buf_chan #(.DEPTH(DEPTH)) u_chan_a (
      .clk     (Clk),
      .rst_n   (Rst_n),
      .push    (push_a),
      .wr_data (In),
      .pop_req (ReadyA),
      .rd_data (A),
      .valid   (ValidA),
      .full    (full_a),
      .level   (LevelA)
   );

   demux1x2_4b_buf_chan #(.DEPTH(DEPTH)) u_chan_b (
      .clk     (Clk),
      .rst_n   (Rst_n),
      .push    (push_b),
      .wr_data (In),
      .pop_req (ReadyB),
      .rd_data (B),
      .valid   (ValidB),
      .full    (full_b),
      .level   (LevelB)
   );

endmodule

// File: tb/tb_demux1x2_4b_buf.sv
// Bench for demux1x2_4b_buf: a table of per-cycle vectors with hand-computed
// readiness/levels, plus a queue model that predicts every head word.

module tb_demux1x2_4b_buf;

   localparam int DEPTH = 2;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          Clk = 1'b0;
   logic          Rst_n = 1'b0;
   logic [3:0]    In = '0;
   logic          InValid = 1'b0;
   logic          InReady;
   logic          Sel = 1'b0;
   logic [3:0]    A;
   logic          ValidA;
   logic          ReadyA = 1'b0;
   logic [3:0]    B;
   logic          ValidB;
   logic          ReadyB = 1'b0;
   logic [LW-1:0] LevelA;
   logic [LW-1:0] LevelB;

   int checks = 0;
   int failures = 0;

   logic [3:0] qa[$];
   logic [3:0] qb[$];

   demux1x2_4b_buf #(.DEPTH(DEPTH)) dut (
      .Clk     (Clk),
      .Rst_n   (Rst_n),
      .In      (In),
      .InValid (InValid),
      .InReady (InReady),
      .Sel     (Sel),
      .A       (A),
      .ValidA  (ValidA),
      .ReadyA  (ReadyA),
      .B       (B),
      .ValidB  (ValidB),
      .ReadyB  (ReadyB),
      .LevelA  (LevelA),
      .LevelB  (LevelB)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [3:0] din;
      logic       sel;
      logic       iv;
      logic       ra;
      logic       rb;
      logic       exp_rdy;
      int         exp_la;
      int         exp_lb;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Compare every output against the queue model (state before the next edge).
   task automatic check_model();
      int exp_a;
      int exp_b;
      int exp_rdy;
      exp_a   = (qa.size() > 0) ? int'(qa[0]) : 0;
      exp_b   = (qb.size() > 0) ? int'(qb[0]) : 0;
      exp_rdy = Sel ? int'(qb.size() < DEPTH) : int'(qa.size() < DEPTH);
      chk("ValidA", int'(ValidA), int'(qa.size() > 0));
      chk("A", int'(A), exp_a);
      chk("LevelA", int'(LevelA), qa.size());
      chk("ValidB", int'(ValidB), int'(qb.size() > 0));
      chk("B", int'(B), exp_b);
      chk("LevelB", int'(LevelB), qb.size());
      chk("InReady", int'(InReady), exp_rdy);
   endtask

   task automatic drive(input logic [3:0] d, input logic s, input logic iv,
                        input logic ra, input logic rb);
      @(negedge Clk);
      In = d; Sel = s; InValid = iv; ReadyA = ra; ReadyB = rb;
      #1;
      check_model();
   endtask

   // Advance the model across one rising edge using only the model's own state.
   task automatic edge_update();
      logic pa, pb, pu_a, pu_b;
      pa   = ReadyA && (qa.size() > 0);
      pb   = ReadyB && (qb.size() > 0);
      pu_a = InValid && !Sel && (qa.size() < DEPTH);
      pu_b = InValid &&  Sel && (qb.size() < DEPTH);
      @(posedge Clk);
      if (pa) void'(qa.pop_front());
      if (pb) void'(qb.pop_front());
      if (pu_a) qa.push_back(In);
      if (pu_b) qb.push_back(In);
   endtask

   vec_t vecs[$];

   initial begin
      //              din   sel   iv    ra    rb    rdy   la lb
      vecs.push_back('{4'hA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0}); // single route
      vecs.push_back('{4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 0});
      vecs.push_back('{4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1, 0});
      vecs.push_back('{4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0}); // fill
      vecs.push_back('{4'h2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1, 0});
      vecs.push_back('{4'h3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2, 0}); // stalled
      vecs.push_back('{4'h3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2, 0});
      vecs.push_back('{4'h3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2, 0}); // no bypass
      vecs.push_back('{4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1, 0});
      vecs.push_back('{4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0}); // ready ignored
      vecs.push_back('{4'h7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0});
      vecs.push_back('{4'h8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1, 0}); // push+pop A
      vecs.push_back('{4'h9, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1, 0}); // push B, pop A
      vecs.push_back('{4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1});
      vecs.push_back('{4'h3, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0, 0}); // interleave
      vecs.push_back('{4'hB, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1, 0});
      vecs.push_back('{4'h5, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0, 1});
      vecs.push_back('{4'hC, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1, 0});
      vecs.push_back('{4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0, 1});
      vecs.push_back('{4'hF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0});

      // Reset state, including InReady held high for both selects.
      #2;
      chk("rst_LevelA", int'(LevelA), 0);
      chk("rst_ValidA", int'(ValidA), 0);
      chk("rst_A", int'(A), 0);
      chk("rst_ValidB", int'(ValidB), 0);
      chk("rst_InReady_sel0", int'(InReady), 1);
      Sel = 1'b1; #1;
      chk("rst_InReady_sel1", int'(InReady), 1);
      Sel = 1'b0;
      @(negedge Clk);
      Rst_n = 1'b1;

      foreach (vecs[i]) begin
         drive(vecs[i].din, vecs[i].sel, vecs[i].iv, vecs[i].ra, vecs[i].rb);
         chk($sformatf("vec%0d_InReady", i), int'(InReady), int'(vecs[i].exp_rdy));
         chk($sformatf("vec%0d_LevelA", i), int'(LevelA), vecs[i].exp_la);
         chk($sformatf("vec%0d_LevelB", i), int'(LevelB), vecs[i].exp_lb);
         edge_update();
      end

      // Reset mid-operation: LevelA=2, LevelB=1, then pulse Rst_n between edges.
      drive(4'h4, 1'b0, 1'b1, 1'b0, 1'b0); edge_update();
      drive(4'h6, 1'b0, 1'b1, 1'b0, 1'b0); edge_update();
      drive(4'hD, 1'b1, 1'b1, 1'b0, 1'b0); edge_update();
      drive(4'hE, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("mid_LevelA_pre", int'(LevelA), 2);
      chk("mid_LevelB_pre", int'(LevelB), 1);
      #1;
      Rst_n = 1'b0;
      qa.delete();
      qb.delete();
      #1;
      chk("mid_LevelA_rst", int'(LevelA), 0);
      chk("mid_LevelB_rst", int'(LevelB), 0);
      chk("mid_ValidA_rst", int'(ValidA), 0);
      chk("mid_A_rst", int'(A), 0);
      chk("mid_B_rst", int'(B), 0);
      Sel = 1'b0; #1;
      chk("mid_InReady_sel0", int'(InReady), 1);
      Sel = 1'b1; InValid = 1'b1; In = 4'h9; #1;
      chk("mid_InReady_sel1", int'(InReady), 1);
      @(posedge Clk);
      #1;
      chk("rst_no_push", int'(LevelB), 0);
      @(negedge Clk);
      Rst_n = 1'b1;
      InValid = 1'b0;
      #1;
      check_model();
      // First push lands on the first edge after release.
      drive(4'h5, 1'b0, 1'b1, 1'b0, 1'b0); edge_update();
      drive(4'h0, 1'b0, 1'b0, 1'b1, 1'b1);
      chk("post_rst_A", int'(A), 5);
      edge_update();
      drive(4'h0, 1'b0, 1'b0, 1'b1, 1'b1); edge_update();

      // Random traffic, checked against the queue model every cycle.
      for (int n = 0; n < 400; n++) begin
         drive(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
               1'($urandom_range(0, 2) == 0));
         edge_update();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
